spi_data_fifo: RTL and testbench



---
 rtl/spi_data_fifo.sv | 121 ++++++++++++
 tb/tb_spi_data_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_data_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, occupancy count and sticky error flags.
// Optional almost-full/almost-empty ports are built only when SPI_FIFO_LEVEL_EN is defined.
module spi_data_fifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned AF_LEVEL     = 6,
  parameter int unsigned AE_LEVEL     = 2,
  parameter int unsigned LOG_DEPTH    = $clog2(BUFFER_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [LOG_DEPTH:0]    elements,
  output logic                  full,
  output logic                  empty,
`ifdef SPI_FIFO_LEVEL_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  output logic                  ovf_err,
  output logic                  udf_err
);

  localparam bit PARAMS_OK = (BUFFER_DEPTH >= 2)
                          && ((BUFFER_DEPTH & (BUFFER_DEPTH - 1)) == 0)
                          && (LOG_DEPTH == $clog2(BUFFER_DEPTH))
                          && (AF_LEVEL >= 1) && (AF_LEVEL <= BUFFER_DEPTH)
                          && (AE_LEVEL < BUFFER_DEPTH)
                          && (DATA_WIDTH >= 1);

  if (!PARAMS_OK) begin : g_param_check
    $error("spi_data_fifo: illegal parameter combination");
  end

  localparam logic [LOG_DEPTH:0]   DEPTH_L  = (LOG_DEPTH+1)'(BUFFER_DEPTH);
  localparam logic [LOG_DEPTH:0]   ELEM_ONE = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];

  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   elements_q, elements_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  logic full_s, empty_s, push, pop;

  assign full_s  = (elements_q == DEPTH_L);
  assign empty_s = (elements_q == '0);
  assign push    = data_in_valid  & ~full_s;
  assign pop     = data_out_ready & ~empty_s;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    elements_d = elements_q;
    ovf_d      = ovf_q | (data_in_valid & full_s);
    udf_d      = udf_q | (data_out_ready & empty_s);
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      elements_d = '0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   elements_d = elements_q + ELEM_ONE;
        2'b01:   elements_d = elements_q - ELEM_ONE;
        default: elements_d = elements_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      elements_q <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      elements_q <= elements_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is not reset; the write is still gated so reset and flush cycles complete no push.
  always_ff @(posedge clk) begin
    if (rstn && !clr && push) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out       = empty_s ? '0 : mem_q[rd_ptr_q];
  assign data_out_valid = ~empty_s;
  assign data_in_ready  = ~full_s;
  assign elements       = elements_q;
  assign full           = full_s;
  assign empty          = empty_s;
  assign ovf_err        = ovf_q;
  assign udf_err        = udf_q;

`ifdef SPI_FIFO_LEVEL_EN
  localparam logic [LOG_DEPTH:0] AF_L = (LOG_DEPTH+1)'(AF_LEVEL);
  localparam logic [LOG_DEPTH:0] AE_L = (LOG_DEPTH+1)'(AE_LEVEL);

  assign almost_full  = (elements_q >= AF_L);
  assign almost_empty = (elements_q <= AE_L);
`endif

endmodule

// File: tb/tb_spi_data_fifo.sv
// Scoreboard bench for spi_data_fifo: the driver queues accepted words, a negedge monitor checks every pop.
// Level-flag checks are compiled in when SPI_FIFO_LEVEL_EN is defined.
module tb_spi_data_fifo;

  logic        clk = 1'b0;
  logic        rstn, clr;
  logic [31:0] data_in;
  logic        data_in_valid, data_in_ready;
  logic [31:0] data_out;
  logic        data_out_valid, data_out_ready;
  logic [3:0]  elements;
  logic        full, empty, ovf_err, udf_err;
`ifdef SPI_FIFO_LEVEL_EN
  logic        almost_full, almost_empty;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int          model_cnt = 0;
  logic        model_ovf = 1'b0;
  logic        model_udf = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  spi_data_fifo #(
    .DATA_WIDTH  (32),
    .BUFFER_DEPTH(8),
    .AF_LEVEL    (6),
    .AE_LEVEL    (2)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .clr           (clr),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .elements      (elements),
    .full          (full),
    .empty         (empty),
`ifdef SPI_FIFO_LEVEL_EN
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
`endif
    .ovf_err       (ovf_err),
    .udf_err       (udf_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: a pop completes at the next edge whenever valid & ready are seen mid-cycle.
  always @(negedge clk) begin
    if (rstn === 1'b1 && clr === 1'b0 && data_out_valid === 1'b1 && data_out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_pop actual=%h expected=no_word", data_out);
      end else begin
        chk("pop_data", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic check_state(input string tag);
    chk({tag, ".elements"}, 32'(elements), 32'(model_cnt));
    chk({tag, ".full"}, 32'(full), 32'(model_cnt == 8));
    chk({tag, ".empty"}, 32'(empty), 32'(model_cnt == 0));
    chk({tag, ".din_ready"}, 32'(data_in_ready), 32'(model_cnt != 8));
    chk({tag, ".dout_valid"}, 32'(data_out_valid), 32'(model_cnt != 0));
    chk({tag, ".ovf_err"}, 32'(ovf_err), 32'(model_ovf));
    chk({tag, ".udf_err"}, 32'(udf_err), 32'(model_udf));
    if (model_cnt == 0) chk({tag, ".dout_zero"}, data_out, 32'h0);
`ifdef SPI_FIFO_LEVEL_EN
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(model_cnt >= 6));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(model_cnt <= 2));
`endif
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c);
    logic push_ok, pop_ok;
    data_in_valid  = v;
    data_in        = d;
    data_out_ready = r;
    clr            = c;
    push_ok = v && (model_cnt < 8) && !c;
    pop_ok  = r && (model_cnt > 0) && !c;
    if (push_ok) exp_q.push_back(d);
    if (!c && v && model_cnt == 8) model_ovf = 1'b1;
    if (!c && r && model_cnt == 0) model_udf = 1'b1;
    @(posedge clk);
    #1;
    if (c) begin
      model_cnt = 0;
      model_ovf = 1'b0;
      model_udf = 1'b0;
      exp_q.delete();
    end else begin
      model_cnt = model_cnt + int'(push_ok) - int'(pop_ok);
    end
    data_in_valid  = 1'b0;
    data_in        = '0;
    data_out_ready = 1'b0;
    clr            = 1'b0;
  endtask

  task automatic reset_cycle(input logic v, input logic [31:0] d, input logic r);
    rstn           = 1'b0;
    data_in_valid  = v;
    data_in        = d;
    data_out_ready = r;
    @(posedge clk);
    #1;
    model_cnt = 0;
    model_ovf = 1'b0;
    model_udf = 1'b0;
    exp_q.delete();
    rstn           = 1'b1;
    data_in_valid  = 1'b0;
    data_in        = '0;
    data_out_ready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0;
    data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    chk("reset.elements_lit", 32'(elements), 32'd0);
    rstn = 1'b1;

    // Fill back to back with no consumer
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'hA5A5_0000 + 32'(i), 1'b0, 1'b0);
      check_state("fill");
    end
    chk("fill.full_lit", 32'(full), 32'd1);
    chk("fill.elements_lit", 32'(elements), 32'd8);

    // Full with simultaneous push and pop: only the pop happens
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check_state("full_pushpop");
    chk("full_pushpop.elements_lit", 32'(elements), 32'd7);
    chk("full_pushpop.ovf_lit", 32'(ovf_err), 32'd1);

    for (int i = 0; i < 7; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check_state("drain");
    end

    // Empty FIFO: word appears one cycle after its push
    chk("empty.valid_before", 32'(data_out_valid), 32'd0);
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    chk("empty.valid_after", 32'(data_out_valid), 32'd1);
    chk("empty.data_after", data_out, 32'h1234_5678);
    step(1'b0, '0, 1'b1, 1'b0);
    check_state("empty_pop");
    step(1'b0, '0, 1'b1, 1'b0);
    check_state("underflow");
    chk("underflow.udf_lit", 32'(udf_err), 32'd1);

    // Flush with a concurrent push and pop
    for (int i = 1; i <= 5; i++) step(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    check_state("pre_clr");
    step(1'b1, 32'hC0DE_0000, 1'b1, 1'b1);
    check_state("clr");
    chk("clr.elements_lit", 32'(elements), 32'd0);
    chk("clr.ovf_lit", 32'(ovf_err), 32'd0);
    chk("clr.udf_lit", 32'(udf_err), 32'd0);
    step(1'b1, 32'h0000_1111, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_state("post_clr");

    // Streaming at occupancy 4 across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_0100 + 32'(i), 1'b0, 1'b0);
    for (int i = 4; i < 104; i++) begin
      step(1'b1, 32'h0000_0100 + 32'(i), 1'b1, 1'b0);
      chk("stream.elements", 32'(elements), 32'd4);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    check_state("stream_done");

    // Level sweep 0 -> 8 -> 0
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h0000_7700 + 32'(i), 1'b0, 1'b0);
      check_state("level_up");
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check_state("level_down");
    end

    // Reset mid-operation with a handshake offered in the reset cycle
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_9900 + 32'(i), 1'b0, 1'b0);
    reset_cycle(1'b1, 32'h0000_99FF, 1'b1);
    check_state("midreset");
    step(1'b1, 32'h0000_AAAA, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_state("after_midreset");

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
